encoder_sync_ctrl: RTL and testbench
====================================

# encoder_sync_ctrl

Scheduler that decides when the per-channel encoder interfaces snapshot their step counter and position into their synced registers. It sits between the PWM carrier event sources and up to N_CH encoder channels. From carrier events (decimated) or a software request, it issues one-cycle `trigger` pulses to all enabled channels. It then waits for every channel's `done` handshake and raises a single `sample_valid` strobe so control code reads a coherent multi-channel sample.

## Interface
- N_CH, 4, number of encoder channels served
- DIV_W, 8, width of event decimation ratio
- TO_W, 8, width of timeout cycle count
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ch_en  in  N_CH  channels included in a sample
- event_sel  in  2  00 none, 01 carrier high, 10 carrier low, 11 both
- carrier_high, carrier_low  in  1 each  single-cycle carrier event pulses
- div_ratio  in  DIV_W  fire on every div_ratio-th qualifying event; 0 is treated as 1
- sw_req  in  1  single-cycle software sample request
- timeout_cycles  in  TO_W  WAIT cycle limit (used only with the timeout feature)
- err_clr  in  1  clears the sticky error flags
- enc_trigger  out  N_CH  trigger pulses to the encoder channels
- enc_done  in  N_CH  done outputs of the encoder channels (idle high)
- busy  out  1  high in any state other than IDLE
- sample_valid  out  1  one-cycle strobe when a sample completes
- sample_mask  out  N_CH  channels that acked in the last sample
- sample_count  out  32  completed samples; wraps at 2^32
- overrun_err  out  1  sticky: a carrier fire was dropped while busy
- timeout_err  out  1  sticky: WAIT exceeded timeout_cycles

## Operation
- Reset values:
  - state IDLE; enc_trigger 0; busy 0; sample_valid 0.
  - sample_mask 0; sample_count 0; overrun_err 0; timeout_err 0.
  - decimation counter 0; pending software request 0.
- Qualifying event: (carrier_high & event_sel[0]) | (carrier_low & event_sel[1]).
  - If both occur in the same cycle, they count once.
- Decimation counter:
  - Increments on each qualifying event.
  - When it reaches max(div_ratio,1)−1 on an event, it produces carrier_fire and returns to 0.
  - It keeps counting while busy.
- States:
  - IDLE:
    - fire = carrier_fire | sw_req | sw_pend.
    - If fire and ch_en≠0: latch mask_q=ch_en, clear sw_pend, go to TRIG.
    - If fire and ch_en=0: discard the request and stay in IDLE.
  - TRIG (1 cycle): enc_trigger=mask_q. Clear ack and seen_low vectors. Go to WAIT.
  - WAIT:
    - Per channel i in mask_q: set seen_low[i] when enc_done[i]=0.
    - Set ack[i] when enc_done[i]=1 and seen_low[i] is set.
    - Go to DONE when ack covers mask_q.
  - DONE (1 cycle):
    - sample_valid=1; sample_mask=ack; sample_count+=1.
    - Go to IDLE.
- Simultaneous carrier_fire and sw_req in IDLE produce one sample; both are consumed.
- While busy:
  - sw_req sets sw_pend (one deep; further requests merge).
  - carrier_fire is dropped and sets overrun_err.
- ch_en changes during a sample have no effect; mask_q is used.
- err_clr clears both sticky flags. A set in the same cycle wins over the clear.

## Timing
- Qualifying event sampled at edge E gives:
  - TRIG in cycle E+1 (enc_trigger high exactly one cycle).
  - WAIT in cycles E+2 and E+3, with a nominal encoder response.
  - DONE with sample_valid high in cycle E+4.
  - IDLE at E+5.
- Minimum spacing between samples: 5 cycles.
- enc_trigger, busy and sample_valid are decoded from registered state; there is no combinational path from inputs to outputs.

## Configuration
- ENC_SYNC_TIMEOUT_EN defined:
  - A TO_W-bit counter runs in WAIT.
  - Once it reaches timeout_cycles, go to DONE with sample_mask=ack (partial) and set timeout_err.
  - timeout_cycles=0 disables the timeout.
- ENC_SYNC_TIMEOUT_EN undefined: WAIT waits indefinitely; timeout_err is tied 0; timeout_cycles is ignored.

## Structure
- Shared package encoder_pkg holds:
  - the state enum (IDLE, TRIG, WAIT, DONE);
  - event_sel encodings;
  - the default widths.
- Sub-module enc_event_decimator: qualification and decimation counter. It outputs carrier_fire.

## Test plan
- Decimation: ch_en=4'b0011, event_sel=01, div_ratio=3, six carrier_high pulses 20 cycles apart, model encoders attached → exactly 2 sample_valid strobes, each 4 cycles after the 3rd/6th pulse; sample_mask=0011; sample_count=2.
- Collision: sw_req and a firing carrier_low in the same IDLE cycle, event_sel=10, div_ratio=1 → one sample; sample_count+1; no pending sample afterwards.
- Busy drop: carrier fire in cycle E+2 of an active sample → no extra sample; overrun_err=1. err_clr then sets overrun_err=0.
- Pending sw: sw_req twice during WAIT → exactly one extra sample, starting TRIG at the cycle after the first returns to IDLE.
- Timeout (macro on): channel 2 done held high, ch_en=0111, timeout_cycles=10 → DONE after 10 WAIT cycles; sample_mask=0011; timeout_err=1.
- Reset mid-WAIT: rst_n low → all outputs at reset values immediately. After release, the next event yields a normal 4-cycle sample.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and defaults for the encoder sampling scheduler.
// Holds the scheduler state encoding, event_sel codes and default widths.
package encoder_pkg;

   localparam int unsigned N_CH_DEF  = 4;
   localparam int unsigned DIV_W_DEF = 8;
   localparam int unsigned TO_W_DEF  = 8;

   localparam logic [1:0] EV_NONE = 2'b00;
   localparam logic [1:0] EV_HIGH = 2'b01;
   localparam logic [1:0] EV_LOW  = 2'b10;
   localparam logic [1:0] EV_BOTH = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_TRIG = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/enc_event_decimator.sv
// Qualifies carrier events against event_sel and decimates them by div_ratio.
// carrier_fire is combinational on the qualifying event so the scheduler can start next edge.
module enc_event_decimator
   import encoder_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       event_sel,
   input  logic             carrier_high,
   input  logic             carrier_low,
   input  logic [DIV_W-1:0] div_ratio,
   output logic             carrier_fire
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] last_cnt;
   logic             qual_ev;

   always_comb begin
      // Coincident high and low events count as a single event.
      qual_ev  = (carrier_high && ((event_sel & EV_HIGH) != EV_NONE)) ||
                 (carrier_low  && ((event_sel & EV_LOW)  != EV_NONE));
      last_cnt = (div_ratio == '0) ? '0 : div_ratio - 1'b1;
      cnt_d        = cnt_q;
      carrier_fire = 1'b0;
      if (qual_ev) begin
         // >= keeps the counter bounded if div_ratio shrinks mid-count.
         if (cnt_q >= last_cnt) begin
            carrier_fire = 1'b1;
            cnt_d        = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/encoder_sync_ctrl.sv
// Schedules coherent multi-channel encoder snapshots: trigger, await done handshakes, strobe.
// Optional WAIT timeout is built when ENC_SYNC_TIMEOUT_EN is defined.
module encoder_sync_ctrl
   import encoder_pkg::*;
#(
   parameter int unsigned N_CH  = N_CH_DEF,
   parameter int unsigned DIV_W = DIV_W_DEF,
   parameter int unsigned TO_W  = TO_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  ch_en,
   input  logic [1:0]       event_sel,
   input  logic             carrier_high,
   input  logic             carrier_low,
   input  logic [DIV_W-1:0] div_ratio,
   input  logic             sw_req,
   input  logic [TO_W-1:0]  timeout_cycles,
   input  logic             err_clr,
   output logic [N_CH-1:0]  enc_trigger,
   input  logic [N_CH-1:0]  enc_done,
   output logic             busy,
   output logic             sample_valid,
   output logic [N_CH-1:0]  sample_mask,
   output logic [31:0]      sample_count,
   output logic             overrun_err,
   output logic             timeout_err
);

   state_e            state_q, state_d;
   logic [N_CH-1:0]   mask_q, mask_d;
   logic [N_CH-1:0]   ack_q, ack_d;
   logic [N_CH-1:0]   seen_low_q, seen_low_d;
   logic              sw_pend_q, sw_pend_d;
   logic [N_CH-1:0]   sample_mask_q, sample_mask_d;
   logic [31:0]       sample_count_q, sample_count_d;
   logic              overrun_q, overrun_d;
   logic              timeout_q, timeout_d;
   logic              timeout_set;
   logic              carrier_fire;
   logic              go_done;

   enc_event_decimator #(.DIV_W(DIV_W)) u_decim (
      .clk          (clk),
      .rst_n        (rst_n),
      .event_sel    (event_sel),
      .carrier_high (carrier_high),
      .carrier_low  (carrier_low),
      .div_ratio    (div_ratio),
      .carrier_fire (carrier_fire)
   );

`ifdef ENC_SYNC_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            to_hit;
   assign to_hit = (timeout_cycles != '0) &&
                   (({1'b0, to_cnt_q} + 1'b1) >= {1'b0, timeout_cycles});
`else
   logic timeout_cycles_unused;
   assign timeout_cycles_unused = ^timeout_cycles;
`endif

   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      ack_d          = ack_q;
      seen_low_d     = seen_low_q;
      sw_pend_d      = sw_pend_q;
      sample_mask_d  = sample_mask_q;
      sample_count_d = sample_count_q;
      timeout_set    = 1'b0;
      go_done        = 1'b0;
`ifdef ENC_SYNC_TIMEOUT_EN
      to_cnt_d       = to_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (carrier_fire || sw_req || sw_pend_q) begin
               sw_pend_d = 1'b0;
               if (ch_en != '0) begin
                  mask_d  = ch_en;
                  state_d = ST_TRIG;
               end
            end
         end
         ST_TRIG: begin
            ack_d      = '0;
            seen_low_d = '0;
            state_d    = ST_WAIT;
`ifdef ENC_SYNC_TIMEOUT_EN
            to_cnt_d   = '0;
`endif
         end
         ST_WAIT: begin
            // Ack needs a low-then-high done so a stale idle-high level is never taken as done.
            seen_low_d = seen_low_q | (mask_q & ~enc_done);
            ack_d      = ack_q | (mask_q & enc_done & seen_low_q);
            if ((ack_d & mask_q) == mask_q) begin
               go_done = 1'b1;
            end
`ifdef ENC_SYNC_TIMEOUT_EN
            else if (to_hit) begin
               go_done     = 1'b1;
               timeout_set = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
            if (go_done) begin
               state_d        = ST_DONE;
               sample_mask_d  = ack_d;
               sample_count_d = sample_count_q + 32'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE && sw_req) sw_pend_d = 1'b1;
      overrun_d = (state_q != ST_IDLE && carrier_fire) || (overrun_q && !err_clr);
      timeout_d = timeout_set || (timeout_q && !err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         mask_q         <= '0;
         ack_q          <= '0;
         seen_low_q     <= '0;
         sw_pend_q      <= 1'b0;
         sample_mask_q  <= '0;
         sample_count_q <= '0;
         overrun_q      <= 1'b0;
         timeout_q      <= 1'b0;
`ifdef ENC_SYNC_TIMEOUT_EN
         to_cnt_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         mask_q         <= mask_d;
         ack_q          <= ack_d;
         seen_low_q     <= seen_low_d;
         sw_pend_q      <= sw_pend_d;
         sample_mask_q  <= sample_mask_d;
         sample_count_q <= sample_count_d;
         overrun_q      <= overrun_d;
         timeout_q      <= timeout_d;
`ifdef ENC_SYNC_TIMEOUT_EN
         to_cnt_q       <= to_cnt_d;
`endif
      end
   end

   assign enc_trigger  = (state_q == ST_TRIG) ? mask_q : '0;
   assign busy         = (state_q != ST_IDLE);
   assign sample_valid = (state_q == ST_DONE);
   assign sample_mask  = sample_mask_q;
   assign sample_count = sample_count_q;
   assign overrun_err  = overrun_q;
   assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_encoder_sync_ctrl.sv
// Self-checking bench for encoder_sync_ctrl: single-sample vector table plus multi-cycle sequences.
// The timeout sequence is compiled in when ENC_SYNC_TIMEOUT_EN is defined.
module tb_encoder_sync_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  ch_en;
   logic [1:0]  event_sel;
   logic        carrier_high, carrier_low;
   logic [7:0]  div_ratio;
   logic        sw_req;
   logic [7:0]  timeout_cycles;
   logic        err_clr;
   logic [3:0]  enc_trigger;
   logic [3:0]  enc_done = 4'b1111;
   logic [3:0]  hold_hi  = 4'b0000;
   logic        busy, sample_valid;
   logic [3:0]  sample_mask;
   logic [31:0] sample_count;
   logic        overrun_err, timeout_err;

   int unsigned nvec = 0;
   int unsigned nfail = 0;
   int unsigned exp_count = 0;

   always #5 clk = ~clk;

   encoder_sync_ctrl #(.N_CH(4), .DIV_W(8), .TO_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ch_en          (ch_en),
      .event_sel      (event_sel),
      .carrier_high   (carrier_high),
      .carrier_low    (carrier_low),
      .div_ratio      (div_ratio),
      .sw_req         (sw_req),
      .timeout_cycles (timeout_cycles),
      .err_clr        (err_clr),
      .enc_trigger    (enc_trigger),
      .enc_done       (enc_done),
      .busy           (busy),
      .sample_valid   (sample_valid),
      .sample_mask    (sample_mask),
      .sample_count   (sample_count),
      .overrun_err    (overrun_err),
      .timeout_err    (timeout_err)
   );

   // Nominal encoder: done drops for the cycle after its trigger, unless held high.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) enc_done[i] <= hold_hi[i] | ~enc_trigger[i];
   end

   typedef struct {
      logic [3:0] ch_en;
      logic [1:0] sel;
      logic [7:0] ratio;
      logic       hi;
      logic       lo;
      logic       sw;
      logic       fire;
      logic [3:0] mask;
   } vec_t;

   vec_t vt[9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      ch_en = v.ch_en; event_sel = v.sel; div_ratio = v.ratio;
      carrier_high = v.hi; carrier_low = v.lo; sw_req = v.sw;
      tick;
      carrier_high = 1'b0; carrier_low = 1'b0; sw_req = 1'b0;
      if (v.fire) begin
         check({tag, " trigger"}, {28'd0, enc_trigger}, {28'd0, v.mask});
         check({tag, " busy"}, {31'd0, busy}, 32'd1);
         tick; tick; tick;
         exp_count++;
         check({tag, " sample_valid"}, {31'd0, sample_valid}, 32'd1);
         check({tag, " sample_mask"}, {28'd0, sample_mask}, {28'd0, v.mask});
         check({tag, " sample_count"}, sample_count, exp_count);
         tick;
         check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
      end else begin
         check({tag, " no trigger"}, {28'd0, enc_trigger}, 32'd0);
         check({tag, " no busy"}, {31'd0, busy}, 32'd0);
         tick; tick; tick; tick;
         check({tag, " no sample"}, {31'd0, sample_valid}, 32'd0);
         check({tag, " count held"}, sample_count, exp_count);
      end
      tick;
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < cycles; k++) begin
         tick;
         if (sample_valid) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      vt[0] = '{4'b0011, 2'b01, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011};
      vt[1] = '{4'b1111, 2'b10, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111};
      vt[2] = '{4'b1111, 2'b01, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
      vt[3] = '{4'b1111, 2'b10, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[4] = '{4'b0101, 2'b11, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0101};
      vt[5] = '{4'b1111, 2'b00, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
      vt[6] = '{4'b1000, 2'b00, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000};
      vt[7] = '{4'b0000, 2'b11, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
      vt[8] = '{4'b0110, 2'b11, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110};

      rst_n = 1'b0; ch_en = '0; event_sel = 2'b00; carrier_high = 1'b0; carrier_low = 1'b0;
      div_ratio = 8'd1; sw_req = 1'b0; timeout_cycles = 8'd0; err_clr = 1'b0;
      tick; tick; tick;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset trigger", {28'd0, enc_trigger}, 32'd0);
      check("reset sample_valid", {31'd0, sample_valid}, 32'd0);
      check("reset sample_mask", {28'd0, sample_mask}, 32'd0);
      check("reset sample_count", sample_count, 32'd0);
      check("reset overrun", {31'd0, overrun_err}, 32'd0);
      check("reset timeout", {31'd0, timeout_err}, 32'd0);
      rst_n = 1'b1;
      tick; tick;

      for (int v = 0; v < 9; v++) run_vec(vt[v], v);

      // Decimation by 3: strobes 4 cycles after the 3rd and 6th pulses.
      ch_en = 4'b0011; event_sel = 2'b01; div_ratio = 8'd3;
      for (int p = 0; p < 6; p++) begin
         carrier_high = 1'b1;
         tick;
         carrier_high = 1'b0;
         for (int k = 1; k < 20; k++) begin
            if ((p == 2 || p == 5) && k == 4) begin
               exp_count++;
               check("decim strobe", {31'd0, sample_valid}, 32'd1);
               check("decim mask", {28'd0, sample_mask}, 32'h3);
            end else begin
               check("decim quiet", {31'd0, sample_valid}, 32'd0);
            end
            tick;
         end
      end
      check("decim count", sample_count, exp_count);

      // Collision: sw_req and a firing carrier_low together give one sample.
      event_sel = 2'b10; div_ratio = 8'd1; ch_en = 4'b0011;
      sw_req = 1'b1; carrier_low = 1'b1;
      tick;
      sw_req = 1'b0; carrier_low = 1'b0;
      check("collide trigger", {28'd0, enc_trigger}, 32'h3);
      tick; tick; tick;
      exp_count++;
      check("collide strobe", {31'd0, sample_valid}, 32'd1);
      check("collide count", sample_count, exp_count);
      expect_quiet("collide no pending", 10);
      check("collide idle", {31'd0, busy}, 32'd0);

      // Busy drop: carrier fire during WAIT is dropped and flags overrun.
      event_sel = 2'b01; div_ratio = 8'd1; ch_en = 4'b0001;
      sw_req = 1'b1; tick; sw_req = 1'b0;
      tick;
      carrier_high = 1'b1; tick; carrier_high = 1'b0;
      check("drop overrun set", {31'd0, overrun_err}, 32'd1);
      tick;
      exp_count++;
      check("drop strobe", {31'd0, sample_valid}, 32'd1);
      check("drop count", sample_count, exp_count);
      expect_quiet("drop no extra", 10);
      check("drop overrun sticky", {31'd0, overrun_err}, 32'd1);
      err_clr = 1'b1; tick; err_clr = 1'b0;
      check("drop overrun cleared", {31'd0, overrun_err}, 32'd0);

      // Overrun set and err_clr in the same cycle: the set wins.
      sw_req = 1'b1; tick; sw_req = 1'b0;
      tick;
      carrier_high = 1'b1; err_clr = 1'b1; tick; carrier_high = 1'b0; err_clr = 1'b0;
      check("set beats clear", {31'd0, overrun_err}, 32'd1);
      tick;
      exp_count++;
      check("set-clear strobe", {31'd0, sample_valid}, 32'd1);
      tick; tick;
      err_clr = 1'b1; tick; err_clr = 1'b0;
      check("set-clear cleared", {31'd0, overrun_err}, 32'd0);

      // Pending software request: two requests in WAIT merge into one extra sample.
      ch_en = 4'b0011;
      sw_req = 1'b1; tick; sw_req = 1'b0;
      tick;
      sw_req = 1'b1; tick;
      tick; sw_req = 1'b0;
      exp_count++;
      check("pend first strobe", {31'd0, sample_valid}, 32'd1);
      tick;
      check("pend idle gap", {31'd0, busy}, 32'd0);
      check("pend idle trigger", {28'd0, enc_trigger}, 32'd0);
      tick;
      check("pend trigger", {28'd0, enc_trigger}, 32'h3);
      tick; tick; tick;
      exp_count++;
      check("pend second strobe", {31'd0, sample_valid}, 32'd1);
      check("pend count", sample_count, exp_count);
      expect_quiet("pend only one", 10);

`ifdef ENC_SYNC_TIMEOUT_EN
      // Timeout: channel 2 never handshakes, 10 WAIT cycles then partial sample.
      hold_hi = 4'b0100; ch_en = 4'b0111; timeout_cycles = 8'd10;
      sw_req = 1'b1; tick; sw_req = 1'b0;
      for (int k = 2; k <= 11; k++) begin
         tick;
         check("timeout waiting", {31'd0, sample_valid}, 32'd0);
      end
      tick;
      exp_count++;
      check("timeout strobe", {31'd0, sample_valid}, 32'd1);
      check("timeout mask", {28'd0, sample_mask}, 32'h3);
      check("timeout err", {31'd0, timeout_err}, 32'd1);
      check("timeout count", sample_count, exp_count);
      tick;
      err_clr = 1'b1; tick; err_clr = 1'b0;
      check("timeout err cleared", {31'd0, timeout_err}, 32'd0);
      hold_hi = 4'b0000; timeout_cycles = 8'd0;
      tick; tick;
`else
      check("timeout tied low", {31'd0, timeout_err}, 32'd0);
`endif

      // Asynchronous reset in WAIT, then a normal sample afterwards.
      ch_en = 4'b0011; overrun_err_set_for_reset();
      sw_req = 1'b1; tick; sw_req = 1'b0;
      tick;
      check("pre-reset busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid reset busy", {31'd0, busy}, 32'd0);
      check("mid reset trigger", {28'd0, enc_trigger}, 32'd0);
      check("mid reset sample_valid", {31'd0, sample_valid}, 32'd0);
      check("mid reset mask", {28'd0, sample_mask}, 32'd0);
      check("mid reset count", sample_count, 32'd0);
      check("mid reset overrun", {31'd0, overrun_err}, 32'd0);
      exp_count = 0;
      tick; tick;
      rst_n = 1'b1;
      tick; tick;
      sw_req = 1'b1; tick; sw_req = 1'b0;
      check("post-reset trigger", {28'd0, enc_trigger}, 32'h3);
      tick; tick; tick;
      exp_count++;
      check("post-reset strobe", {31'd0, sample_valid}, 32'd1);
      check("post-reset mask", {28'd0, sample_mask}, 32'h3);
      check("post-reset count", sample_count, exp_count);
      tick;
      check("post-reset idle", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   // Leaves overrun_err set before the reset so the reset clearing it is observable.
   task automatic overrun_err_set_for_reset;
      event_sel = 2'b01; div_ratio = 8'd1;
      sw_req = 1'b1; tick; sw_req = 1'b0;
      carrier_high = 1'b1; tick; carrier_high = 1'b0;
      check("pre-reset overrun", {31'd0, overrun_err}, 32'd1);
      tick; tick; tick;
   endtask

endmodule
